// File: rtl/reset_sequencer.sv
// Merges filtered reset requests and releases N_STAGE reset outputs in order, with a delay before each stage.
// Latency: request to stage_rst is 2+FILTER_CLK edges; release to SEQ is 3 edges; no backpressure, all outputs registered.
module reset_sequencer #(
    parameter int                         N_SRC      = 4,
    parameter int                         N_STAGE    = 2,
    parameter int                         CNT_W      = 24,
    parameter logic [N_STAGE*CNT_W-1:0]   STAGE_CLK  = {24'd240, 24'd24},
    parameter int                         FILTER_CLK = 4,
    parameter int                         COLD_CLK   = 3000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    req,
    input  logic [N_SRC-1:0]    req_mask,
    input  logic                sw_restart,
    output logic [N_STAGE-1:0]  stage_rst,
    output logic                busy,
    output logic                cold,
    output logic [N_SRC-1:0]    cause
);

    localparam int SW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] SEQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILTER_CLK - 1);
    localparam logic [CNT_W-1:0] COLD_LIM   = CNT_W'(COLD_CLK);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(N_STAGE - 1);

    logic [N_SRC-1:0]   sync1;
    logic [N_SRC-1:0]   sync2;
    logic [N_SRC-1:0]   filt;
    logic [CNT_W-1:0]   fcnt [N_SRC];

    logic [1:0]         state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]   dly_cnt;
    logic [SW-1:0]      stage_idx;
    logic               cold_r;
    logic               cold_pend;

    logic [N_SRC-1:0]   srcs;
    logic               act;
    logic [CNT_W-1:0]   cur_dly;
    logic [N_STAGE-1:0] rel_sel;

    // Filter counts consecutive synchronised-high samples; any low sample drops the output at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < N_SRC; i++) fcnt[i] <= '0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
            for (int i = 0; i < N_SRC; i++) begin
                if (!sync2[i]) begin
                    fcnt[i] <= '0;
                    filt[i] <= 1'b0;
                end else if (fcnt[i] == FILT_LAST) begin
                    filt[i] <= 1'b1;
                end else begin
                    fcnt[i] <= fcnt[i] + ONE;
                end
            end
        end
    end

    assign srcs = filt & ~req_mask;
    assign act  = (|srcs) | sw_restart;

    always_comb begin
        cur_dly = '0;
        rel_sel = '0;
        for (int k = 0; k < N_STAGE; k++) begin
            if (stage_idx == SW'(k)) begin
                cur_dly    = STAGE_CLK[k*CNT_W +: CNT_W];
                rel_sel[k] = 1'b1;
            end
        end
    end

    // A new request takes priority over any stage release on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            dly_cnt   <= '0;
            stage_idx <= '0;
            stage_rst <= '1;
            busy      <= 1'b1;
            cold_r    <= 1'b0;
            cold_pend <= 1'b1;
            cause     <= '0;
        end else if (act && state != HOLD) begin
            state     <= HOLD;
            stage_rst <= '1;
            busy      <= 1'b1;
            hold_cnt  <= '0;
            cause     <= ((state == DONE) ? '0 : cause) | srcs;
        end else begin
            case (state)
                HOLD: begin
                    if (act) begin
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + ONE;
                        cause <= cause | srcs;
                    end else begin
                        state     <= SEQ;
                        cold_r    <= cold_pend | (hold_cnt >= COLD_LIM);
                        cold_pend <= 1'b0;
                        stage_idx <= '0;
                        dly_cnt   <= '0;
                    end
                end
                SEQ: begin
                    if (dly_cnt + ONE == cur_dly) begin
                        stage_rst <= stage_rst & ~rel_sel;
                        dly_cnt   <= '0;
                        if (stage_idx == LAST_STAGE) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            stage_idx <= stage_idx + SW'(1);
                        end
                    end else begin
                        dly_cnt <= dly_cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cold = cold_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer: expected output-change events are computed from request timing and queued.
module tb_reset_sequencer;

    localparam int F    = 4;
    localparam int COLD = 400;
    localparam int D0   = 24;
    localparam int D1   = 240;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_restart = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] req_mask = 4'b0;
    logic [1:0] stage_rst;
    logic       busy;
    logic       cold;
    logic [3:0] cause;

    reset_sequencer #(
        .N_SRC(4), .N_STAGE(2), .CNT_W(24),
        .STAGE_CLK({24'd240, 24'd24}),
        .FILTER_CLK(F), .COLD_CLK(COLD)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_mask(req_mask),
        .sw_restart(sw_restart), .stage_rst(stage_rst), .busy(busy),
        .cold(cold), .cause(cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         e;
        logic [1:0] st;
        logic       b;
        logic       c;
        logic [3:0] ca;
    } ev_t;

    ev_t expq[$];

    // Model of the visible outputs and the last tuple queued
    logic [1:0] m_st = 2'b11, l_st = 2'b11;
    logic       m_busy = 1'b1, l_busy = 1'b1;
    logic       m_cold = 1'b0, l_cold = 1'b0;
    logic [3:0] m_cause = 4'b0, l_cause = 4'b0;
    logic       m_pend = 1'b1;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    logic [8:0] prev;

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic push_ev(input int e);
        ev_t v;
        if ({m_st, m_busy, m_cold, m_cause} != {l_st, l_busy, l_cold, l_cause}) begin
            v.e = e; v.st = m_st; v.b = m_busy; v.c = m_cold; v.ca = m_cause;
            expq.push_back(v);
            l_st = m_st; l_busy = m_busy; l_cold = m_cold; l_cause = m_cause;
        end
    endtask

    task automatic exp_entry(input int n, input logic [3:0] c);
        m_st = 2'b11; m_busy = 1'b1; m_cause = c;
        push_ev(n);
    endtask

    task automatic exp_exit(input int x, input int hold);
        m_cold = m_pend || (hold >= COLD);
        m_pend = 1'b0;
        push_ev(x);
    endtask

    task automatic exp_stages(input int x);
        m_st = 2'b10; push_ev(x + D0);
        m_st = 2'b00; m_busy = 1'b0; push_ev(x + D0 + D1);
    endtask

    // Request held L cycles starting from DONE: filter accepts if L >= F, hold count is L-F.
    task automatic warm_pulse(input logic [3:0] srcs, input logic [3:0] msk, input int L);
        int r;
        logic [3:0] eff;
        @(negedge clk); req_mask = msk;
        @(negedge clk);
        r = cyc + 1;
        eff = srcs & ~msk;
        if (eff != 4'b0 && L >= F) begin
            exp_entry(r + 2 + F, eff);
            exp_exit(r + L + 3, L - F);
            exp_stages(r + L + 3);
        end
        req = srcs;
        repeat (L) @(negedge clk);
        req = 4'b0;
        repeat (D0 + D1 + 12) @(negedge clk);
        req_mask = 4'b0;
    endtask

    // Second request arrives K cycles after stage 0 releases, while stage 1 is still counting.
    task automatic retrigger(input int a, input int b, input int L1, input int K, input int L2);
        int r1, x1, rel0, r2, n2, x2;
        @(negedge clk);
        r1 = cyc + 1;
        x1 = r1 + L1 + 3;
        rel0 = x1 + D0;
        r2 = rel0 + K;
        n2 = r2 + 2 + F;
        x2 = r2 + L2 + 3;
        exp_entry(r1 + 2 + F, 4'(1 << a));
        exp_exit(x1, L1 - F);
        m_st = 2'b10; push_ev(rel0);
        exp_entry(n2, 4'(1 << a) | 4'(1 << b));
        exp_exit(x2, L2 - F);
        exp_stages(x2);
        req[a] = 1'b1;
        repeat (L1) @(negedge clk);
        req = 4'b0;
        while (cyc < r2 - 1) @(negedge clk);
        req[b] = 1'b1;
        repeat (L2) @(negedge clk);
        req = 4'b0;
        repeat (D0 + D1 + 12) @(negedge clk);
    endtask

    task automatic sw_pulse();
        int n;
        @(negedge clk);
        n = cyc + 1;
        exp_entry(n, 4'b0);
        exp_exit(n + 1, 0);
        exp_stages(n + 1);
        sw_restart = 1'b1;
        @(negedge clk);
        sw_restart = 1'b0;
        repeat (D0 + D1 + 12) @(negedge clk);
    endtask

    // Source 3 held high, then masked H cycles into HOLD: mask alone ends the hold.
    task automatic mask_drop(input int H);
        int r, n, x;
        @(negedge clk);
        r = cyc + 1;
        n = r + 2 + F;
        x = n + H + 1;
        exp_entry(n, 4'b1000);
        exp_exit(x, H);
        exp_stages(x);
        req = 4'b1000;
        while (cyc < n + H) @(negedge clk);
        req_mask = 4'b1000;
        repeat (20) @(negedge clk);
        req = 4'b0;
        repeat (D0 + D1 + 12) @(negedge clk);
        req_mask = 4'b0;
    endtask

    always @(negedge clk) begin
        ev_t v;
        logic [8:0] cur;
        if (mon_en) begin
            cur = {stage_rst, busy, cold, cause};
            if (cur != prev) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event @cyc %0d: st=%b busy=%b cold=%b cause=%b",
                             cyc, stage_rst, busy, cold, cause);
                end else begin
                    v = expq.pop_front();
                    if (v.e != cyc || v.st != stage_rst || v.b != busy || v.c != cold || v.ca != cause) begin
                        n_bad++;
                        $display("FAIL event: got cyc %0d st=%b busy=%b cold=%b cause=%b, want cyc %0d st=%b busy=%b cold=%b cause=%b",
                                 cyc, stage_rst, busy, cold, cause, v.e, v.st, v.b, v.c, v.ca);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int R;
        logic [3:0] s, mk;
        int a, b;
        repeat (3) @(negedge clk);
        chk("reset_stage_rst", int'(stage_rst), 3);
        chk("reset_busy", int'(busy), 1);
        chk("reset_cold", int'(cold), 0);
        chk("reset_cause", int'(cause), 0);
        prev = {stage_rst, busy, cold, cause};
        mon_en = 1'b1;

        reset = 1'b0;
        R = cyc + 1;
        exp_exit(R, 0);
        exp_stages(R);
        repeat (D0 + D1 + 12) @(negedge clk);

        warm_pulse(4'b0001, 4'b0000, 100);
        warm_pulse(4'b0100, 4'b0000, 3);
        warm_pulse(4'b1000, 4'b1000, 50);
        warm_pulse(4'b0010, 4'b0000, F + COLD);
        warm_pulse(4'b0010, 4'b0000, F + COLD - 1);
        warm_pulse(4'b0001, 4'b0000, F);
        retrigger(0, 2, 20, 10, 30);
        retrigger(1, 3, F, 234, F + COLD + 5);
        sw_pulse();
        mask_drop($urandom_range(5, 40));

        for (int i = 0; i < 8; i++) begin
            s  = 4'($urandom_range(1, 15));
            mk = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            warm_pulse(s, mk, $urandom_range(1, 140));
        end
        for (int i = 0; i < 2; i++) begin
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            retrigger(a, b, $urandom_range(F, 60), $urandom_range(1, 234), $urandom_range(F, 80));
        end
        sw_pulse();

        repeat (20) @(negedge clk);
        chk("events_outstanding", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-source, multi-stage reset sequencer that replaces the fixed two-output DCLO/ACLO generator. It merges N asynchronous reset requests: front-panel button, PLL unlock, ROM-load wait, OSD reset and keyboard reset. Each request is synchronised and debounced. The block then releases N_STAGE reset outputs in a programmable order with per-stage delays. It also reports the reset cause and classifies each reset as cold or warm, which the memory and model-switch logic consumes.

## Interface
- N_SRC, 4: number of reset request inputs.
- N_STAGE, 2: number of staged reset outputs; stage 0 releases first.
- CNT_W, 24: width of every internal counter.
- STAGE_CLK, {24'd240, 24'd24}: packed N_STAGE*CNT_W release delays.
  - Stage k delay is STAGE_CLK[k*CNT_W +: CNT_W].
  - Each delay must be ≥1.
- FILTER_CLK, 4: consecutive synchronised-high samples needed to accept a request, ≥1.
- COLD_CLK, 3000000: HOLD duration in cycles at or above which a reset is cold.
- clk  in  1  sequencer clock.
- reset  in  1  synchronous, active-high.
- req  in  N_SRC  asynchronous, level-sensitive reset requests, active-high.
- req_mask  in  N_SRC  1 = ignore that source; must be quasi-static.
- sw_restart  in  1  single-cycle synchronous pulse that forces a warm reset.
- stage_rst  out  N_STAGE  1 = stage held in reset.
- busy  out  1  high while any stage_rst bit is high.
- cold  out  1  classification of the last completed HOLD.
- cause  out  N_SRC  sources seen during the current or last reset event.

## Operation
- Synchronisation: every req bit passes through a 2-flop synchroniser and then a per-source filter.
  - Filter output rises after FILTER_CLK consecutive high samples.
  - Filter output falls on the first low sample, with no filtering on release.
- Active request: act = |(filt & ~req_mask) | sw_restart.
- States: HOLD, SEQ, DONE.
- HOLD:
  - All stage_rst = 1.
  - hold_cnt increments and saturates at 2^CNT_W−1.
  - cause |= filt & ~req_mask.
  - Exit to SEQ on the first cycle act = 0.
  - On exit, cold_r <= cold_pend | (hold_cnt ≥ COLD_CLK); cold_pend <= 0.
- SEQ:
  - Stage index s starts at 0 and the delay counter restarts on every stage release.
  - stage_rst[s] clears when the counter reaches STAGE_CLK[s]; s then advances.
  - After stage N_STAGE−1 releases, go to DONE.
- DONE: all stage_rst = 0; hold until act.
- Entry to HOLD from any state on act = 1:
  - All stage_rst set on the same registered edge.
  - hold_cnt cleared.
- cause handling:
  - Entry to HOLD from DONE clears cause before OR-ing in the new sources.
  - Re-entry to HOLD from SEQ keeps cause accumulating.
- sw_restart: a pulse gives exactly one HOLD cycle, then SEQ; it never sets a cause bit.
- cold output: equals cold_r and changes only on HOLD exit.
- Reset forces:
  - state HOLD, hold_cnt = 0;
  - stage_rst all 1, busy 1;
  - cold_r 0, cold_pend 1 (the first release after reset is always cold);
  - cause 0, synchroniser and filter state 0.
- Masking a source while it is high drops it from act on the next cycle.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Assert latency: req rising before edge 0 gives filt high after edge 1+FILTER_CLK and stage_rst high after edge 2+FILTER_CLK.
- Release latency: req falling before edge 0 gives filt low after edge 2 and SEQ entered after edge 3.
- Stage release: stage 0 releases STAGE_CLK[0] edges after SEQ entry; stage k releases STAGE_CLK[k] edges after stage k−1.
- busy falls on the same edge as the last stage_rst bit.
- Simultaneous act and stage release on one edge: act wins, and all stages stay or return to 1.
- A request glitch shorter than FILTER_CLK cycles produces no effect.

## Test plan
- Power-on with defaults:
  - Stimulus: reset high 3 cycles, req = 0.
  - Response: stage_rst = 2'b11 through reset.
  - Response: HOLD lasts 1 cycle, then stage 0 falls 24 edges and stage 1 falls 24+240 edges after SEQ entry.
  - Response: cold = 1 after HOLD exit, cause = 0.
- Warm button reset:
  - Stimulus: req[0] high for 100 cycles, starting after DONE.
  - Response: stage_rst = 11 at edge 6 after the rise.
  - Response: release sequence 24/240 as above, cold = 0, cause = 4'b0001.
- Cold long press:
  - Stimulus: req[1] high for 3,000,010 cycles.
  - Response: cold = 1 after HOLD exit, cause = 4'b0010.
- Glitch and mask:
  - Stimulus: req[2] high for 3 cycles. Response: no change.
  - Stimulus: req[3] high for 50 cycles with req_mask[3] = 1. Response: no change, cause unchanged.
- Re-trigger mid-SEQ:
  - Stimulus: req[0] pulse, then req[2] raised 10 cycles after stage 0 releases.
  - Response: both stages return to 1, cause = 4'b0101, and the full sequence restarts.
- Software restart:
  - Stimulus: sw_restart pulse from DONE.
  - Response: exactly 1 HOLD cycle, then the 24/240 release, cold = 0, cause = 0.
